// File: rtl/sbox_share_scheduler.sv
// Time-shares one pipelined AES S-box between the key schedule (4-byte SubWord)
// and the round datapath (16-byte SubBytes), one byte per cycle, one burst at a time.
module sbox_share_scheduler #(
  parameter int SBOX_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ks_req,
  input  logic [31:0]  ks_word_in,
  output logic         ks_gnt,
  output logic         ks_done,
  output logic [31:0]  ks_word_out,
  input  logic         ds_req,
  input  logic [127:0] ds_state_in,
  output logic         ds_gnt,
  output logic         ds_done,
  output logic [127:0] ds_state_out,
  output logic [7:0]   sb_in,
  output logic         sb_valid,
  input  logic [7:0]   sb_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r;
  logic           last_ks_r;
  logic           cur_ks_r;
  logic [127:0]   operand_r;
  logic [127:0]   result_r;
  logic [3:0]     idx_r;
  logic [127:0]   result_next_s;
  logic [3:0]     last_idx_s;
  logic           ks_win_s;
  logic           ds_win_s;
  logic           wr_vld_s;
  logic [3:0]     wr_idx_s;
  logic           wr_last_s;

  // Round-robin arbitration; the grant cycle is the last idle cycle
  always_comb begin
    ks_win_s = 1'b0;
    ds_win_s = 1'b0;
    if (state_r == IDLE) begin
      ks_win_s = ks_req & (~ds_req | ~last_ks_r);
      ds_win_s = ds_req & ~ks_win_s;
    end else begin
      ks_win_s = 1'b0;
      ds_win_s = 1'b0;
    end
  end

  assign ks_gnt     = ks_win_s;
  assign ds_gnt     = ds_win_s;
  assign busy       = (state_r != IDLE) | ks_win_s | ds_win_s;
  assign last_idx_s = cur_ks_r ? 4'd3 : 4'd15;

  // Merge the returning S-box byte into the partial result
  always_comb begin
    result_next_s = result_r;
    wr_last_s     = 1'b0;
    if (wr_vld_s) begin
      result_next_s[{wr_idx_s, 3'b000} +: 8] = sb_out;
      wr_last_s = (wr_idx_s == last_idx_s);
    end else begin
      wr_last_s = 1'b0;
    end
  end

  generate
    if (SBOX_LAT == 0) begin : g_no_pipe
      assign wr_vld_s = sb_valid;
      assign wr_idx_s = idx_r;
    end else begin : g_pipe
      logic [SBOX_LAT-1:0] vld_pipe_r;
      logic [3:0]          idx_pipe_r [SBOX_LAT];

      // Valid/index shadow travelling alongside the external S-box pipeline
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe_r <= {SBOX_LAT{1'b0}};
          for (int i = 0; i < SBOX_LAT; i++) idx_pipe_r[i] <= 4'd0;
        end else begin
          vld_pipe_r[0] <= sb_valid;
          idx_pipe_r[0] <= idx_r;
          for (int i = 1; i < SBOX_LAT; i++) begin
            vld_pipe_r[i] <= vld_pipe_r[i-1];
            idx_pipe_r[i] <= idx_pipe_r[i-1];
          end
        end
      end

      assign wr_vld_s = vld_pipe_r[SBOX_LAT-1];
      assign wr_idx_s = idx_pipe_r[SBOX_LAT-1];
    end
  endgenerate

  // Burst FSM: capture, issue bytes, collect results, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_ks_r    <= 1'b0;
      cur_ks_r     <= 1'b0;
      operand_r    <= 128'd0;
      result_r     <= 128'd0;
      idx_r        <= 4'd0;
      sb_in        <= 8'd0;
      sb_valid     <= 1'b0;
      ks_done      <= 1'b0;
      ds_done      <= 1'b0;
      ks_word_out  <= 32'd0;
      ds_state_out <= 128'd0;
    end else begin
      ks_done  <= 1'b0;
      ds_done  <= 1'b0;
      result_r <= result_next_s;
      case (state_r)
        IDLE: begin
          if (ks_win_s | ds_win_s) begin
            state_r   <= ISSUE;
            last_ks_r <= ks_win_s;
            cur_ks_r  <= ks_win_s;
            operand_r <= ks_win_s ? {96'd0, ks_word_in} : ds_state_in;
            result_r  <= 128'd0;
            idx_r     <= 4'd0;
            sb_in     <= ks_win_s ? ks_word_in[7:0] : ds_state_in[7:0];
            sb_valid  <= 1'b1;
          end
        end
        ISSUE: begin
          if (idx_r == last_idx_s) begin
            state_r  <= DRAIN;
            sb_in    <= 8'd0;
            sb_valid <= 1'b0;
          end else begin
            idx_r <= idx_r + 4'd1;
            sb_in <= operand_r[{idx_r + 4'd1, 3'b000} +: 8];
          end
        end
        DRAIN:   state_r <= DRAIN;
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      // Last byte back: overrides ISSUE/DRAIN so a zero-latency S-box skips DRAIN
      if (wr_last_s) begin
        state_r <= DONE;
        if (cur_ks_r) begin
          ks_done     <= 1'b1;
          ks_word_out <= result_next_s[31:0];
        end else begin
          ds_done      <= 1'b1;
          ds_state_out <= result_next_s;
        end
      end
    end
  end

endmodule

// File: doc/sbox_share_scheduler.md
Name: sbox_share_scheduler

Overview:
Time-shares one pipelined composite-field AES S-box between two requesters. The composite-field S-box is built from the GF(2^8)/GF(2^4)/GF(2^2) inverter chain. The requesters are the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). The block grants one burst at a time and feeds operand bytes into the S-box one per cycle. It tracks in-flight bytes through the S-box latency, reassembles the results and returns them with a done pulse.

Parameters:
SBOX_LAT, 2, S-box pipeline depth in cycles. Legal range 0..7; 0 means sb_out is combinational from sb_in.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ks_req  in  1  key-schedule request; ks_word_in must be stable while high
ks_word_in  in  32  SubWord operand; byte i = bits [8i+7:8i]
ks_gnt  out  1  one-cycle pulse; operand captured this cycle
ks_done  out  1  one-cycle pulse; ks_word_out valid
ks_word_out  out  32  SubWord result; held until next ks_done
ds_req  in  1  datapath request; ds_state_in must be stable while high
ds_state_in  in  128  SubBytes operand; byte i = bits [8i+7:8i]
ds_gnt  out  1  one-cycle pulse; operand captured this cycle
ds_done  out  1  one-cycle pulse; ds_state_out valid
ds_state_out  out  128  SubBytes result; held until next ds_done
sb_in  out  8  byte driven to the shared S-box
sb_valid  out  1  high in cycles where sb_in carries a real operand byte
sb_out  in  8  S-box result for the sb_in presented SBOX_LAT cycles earlier
busy  out  1  high from the grant cycle until the done cycle, inclusive

Behaviour:
- Reset (async assert, sync release): every output is 0, FSM goes to IDLE, last_served = DS, the in-flight valid shift register is cleared, and the captured operands and partial results are cleared.
- FSM states:
  - IDLE: no burst active.
  - ISSUE: bytes being sent to the S-box.
  - DRAIN: waiting for in-flight bytes to return.
  - DONE: one cycle; the done pulse is asserted.
- IDLE → grant:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_served (round-robin). After reset, KS wins first.
  - The gnt pulse happens in the grant cycle T. The operand is registered at the end of T and last_served is updated.
  - With no req, stay in IDLE.
- ISSUE:
  - Runs for N cycles, T+1..T+N, where N = 4 for KS and 16 for DS.
  - sb_in = operand byte k in cycle T+1+k, in ascending order, with sb_valid = 1.
  - Outside ISSUE, sb_valid = 0 and sb_in = 0.
- Result collection:
  - A SBOX_LAT-deep shift register carries valid and byte index alongside the S-box pipeline.
  - sb_out is written into result byte k at the end of cycle T+1+k+SBOX_LAT.
  - When SBOX_LAT = 0, writes occur during ISSUE itself and DRAIN is skipped.
- DRAIN: lasts until the last byte is captured at the end of cycle T+N+SBOX_LAT.
- DONE:
  - Occurs in cycle T+N+SBOX_LAT+1. The matching done is asserted and the matching result output updates at the same edge that asserts done.
  - Total latency from gnt to done: KS = 5+SBOX_LAT cycles; DS = 17+SBOX_LAT cycles.
- Back-to-back operation:
  - The block returns to IDLE after the DONE cycle. The earliest next gnt is the cycle after done.
  - Bursts never overlap and are never preempted.
- req is ignored while busy. A req that drops before gnt is never granted. A req still high after gnt is treated as a new request at the next IDLE; the requester must drop req in the cycle after gnt if it wants only one burst.
- The result output of the requester not being served is never modified.
- Reset mid-burst discards all partial results, and no done is issued. Requesters re-request after reset.
- At most one of ks_gnt/ds_gnt and at most one of ks_done/ds_done is high in any cycle.

Test Plan:
1. Reset, then ks_req with ks_word_in = 0x015300FF, SBOX_LAT = 2 → ks_gnt at T; sb_in sequence FF,00,53,01 in T+1..T+4; ks_done at T+7; ks_word_out = 0x7CED6316.
2. ds_req with ds_state_in = all 0x00 → ds_done 19 cycles after ds_gnt; ds_state_out = all 0x63; ks_word_out unchanged.
3. ks_req and ds_req both held high from reset → order of grants KS, DS, KS, DS. Each gnt occurs the cycle after the previous done; neither requester starves.
4. Rebuild the bench with SBOX_LAT = 0, KS word 0x00000000 → ks_done 5 cycles after gnt; result 0x63636363; DRAIN not entered.
5. Assert rst_n low 6 cycles into a DS burst → all outputs 0 immediately. No ds_done follows. A fresh ds_req after release completes correctly with 0xFF bytes → 0x16.
6. Pulse ds_req high for one cycle while a KS burst is busy → no ds_gnt; the KS result is still correct; the block returns to IDLE with busy = 0.
